// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic in-order pipeline buffer with valid/ready, flush and occupancy.
// Define PIPE_STAGE_BUF_PERF_EN to add the saturating stall_cycles counter port.
module pipe_stage_buf #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic push, pop;
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // ready depends only on registered count, so out_ready never reaches in_ready
  always_comb begin
    in_ready  = count != CNT_W'(DEPTH);
    out_valid = count != '0;
    out_data  = out_valid ? mem[head] : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end
  always_ff @(posedge clk)
    if (push && !flush && !rst) mem[tail] <= in_data;
  always_ff @(posedge clk)
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop) head <= next_ptr(head);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
`ifdef PIPE_STAGE_BUF_PERF_EN
  always_ff @(posedge clk)
    if (rst) stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: queue-model scoreboard bench driving DEPTH=2 and DEPTH=3 buffers in parallel.
module tb_pipe_stage_buf;
  localparam int W = 8;
  logic clk = 0, rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic ir [2];
  logic ov [2];
  logic [W-1:0] od [2];
  logic [1:0] cnt [2];
  logic [W-1:0] q [2][$];
  logic [W-1:0] lg [2][$];
  int unsigned st [2];
  int checks = 0, errors = 0;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] sc [2];
`endif
  always #5 clk = ~clk;
  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(cnt[0])
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cycles(sc[0])
`endif
  );
  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(cnt[1])
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cycles(sc[1])
`endif
  );
  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", n, i, a, e);
    end
  endtask
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f = 1'b0);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask
  // reference model: a plain FIFO queue of capacity i+2 per buffer
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      bit pu, po;
      if (rst) begin
        q[i].delete();
        st[i] = 0;
      end else begin
        if (q[i].size() > 0 && !out_ready && st[i] != 32'hFFFF_FFFF) st[i]++;
        if (flush) q[i].delete();
        else begin
          po = out_ready && q[i].size() > 0;
          pu = in_valid && q[i].size() < i + 2;
          if (po) void'(q[i].pop_front());
          if (pu) q[i].push_back(in_data);
        end
      end
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("count", i, 32'(cnt[i]), q[i].size());
      chk("in_ready", i, 32'(ir[i]), 32'(q[i].size() < i + 2));
      chk("out_valid", i, 32'(ov[i]), 32'(q[i].size() != 0));
      chk("out_data", i, 32'(od[i]), q[i].size() != 0 ? 32'(q[i][0]) : 32'd0);
`ifdef PIPE_STAGE_BUF_PERF_EN
      chk("stall_cycles", i, sc[i], st[i]);
`endif
      if (ov[i] && out_ready && !rst && !flush) lg[i].push_back(od[i]);
    end
  initial begin
    int k, n;
    bit v, acc;
    void'($urandom(1234));
    rst = 1;
    cyc(1, 8'h55, 0);
    cyc(1, 8'h55, 0);
    rst = 0;
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(0, 0, 0);
    chk("fill_count", 0, 32'(cnt[0]), 2);
    chk("fill_data", 0, 32'(od[0]), 32'h11);
    for (int j = 0; j < 3; j++) cyc(0, 0, 1);
    for (int i = 0; i < 2; i++) lg[i].delete();
    for (int j = 0; j < 100; j++) cyc(1, 8'(j), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("stream_len", 0, lg[0].size(), 100);
    for (int j = 0; j < lg[0].size(); j++) chk("stream_word", 0, 32'(lg[0][j]), j);
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'hAA, 1, 1);
    chk("flush_count", 0, 32'(cnt[0]), 0);
    chk("flush_valid", 0, 32'(ov[0]), 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 2; i++) lg[i].delete();
    k = 0;
    n = 0;
    while (k < 50 && n < 3000) begin
      v = 1'($urandom_range(0, 1));
      acc = v && q[1].size() < 3;
      cyc(v, 8'(128 + k), 1'($urandom_range(0, 1)));
      if (acc) k++;
      n++;
    end
    chk("rand_done", 1, k, 50);
    for (int j = 0; j < 4; j++) cyc(0, 0, 1);
    chk("rand_len", 1, lg[1].size(), 50);
    for (int j = 0; j < lg[1].size(); j++) chk("rand_word", 1, 32'(lg[1][j]), 128 + j);
`ifdef PIPE_STAGE_BUF_PERF_EN
    rst = 1;
    cyc(0, 0, 0);
    rst = 0;
    cyc(1, 8'h33, 0);
    for (int j = 0; j < 5; j++) cyc(0, 0, 0);
    chk("stall5", 0, sc[0], 5);
    cyc(0, 0, 1, 1);
    chk("stall_flush", 0, sc[0], 5);
    cyc(1, 8'h44, 0);
    force u2.stall_cycles = 32'hFFFF_FFFD;
    st[0] = 32'hFFFF_FFFD;
    #1 release u2.stall_cycles;
    for (int j = 0; j < 5; j++) cyc(0, 0, 0);
    chk("stall_sat", 0, sc[0], 32'hFFFF_FFFF);
`endif
    cyc(1, 8'h05, 0);
    cyc(1, 8'h06, 0);
    rst = 1;
    cyc(1, 8'h07, 1);
    rst = 0;
    chk("rst_count", 0, 32'(cnt[0]), 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
